// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver for 8N1-style frames: one start bit, D_BITS data
// bits sent LSB first, SP_BITS stop bits and no parity. It is the receive side
// of the link whose transmit side is the team's UART transmitter. The raw line
// is synchronised, bit periods are timed with an internal counter, the start
// bit is confirmed at half a bit, and each bit is sampled at mid-period.
//
// Ports
//   i_clk        system clock; all logic runs on its rising edge
//   i_rst        synchronous active-high reset
//   i_rx         raw asynchronous serial line, idles high
//   o_data       last correctly framed word; bit 0 is the first data bit
//   o_rx_done    one-cycle pulse; o_data is updated in the same cycle
//   o_frame_err  one-cycle pulse when a stop bit is sampled low
//   o_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int clk_speed = 100_000000,
  parameter int baudrate  = 921600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic [D_BITS-1:0] o_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  // Rounded clocks per bit; 109 at the default clock and baud rate.
  localparam int DIV   = (clk_speed + baudrate / 2) / baudrate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (D_BITS > 1) ? $clog2(D_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(D_BITS - 1);
  localparam logic             STOP_LAST     = (SP_BITS == 2) ? 1'b1 : 1'b0;

  // Parameter sanity: the half-bit start check needs a few cycles per bit.
  if (DIV < 4) begin : g_div_check
    $error("uart_rx: clk_speed/baudrate gives fewer than 4 clocks per bit");
  end
  if ((SP_BITS != 1) && (SP_BITS != 2)) begin : g_stop_check
    $error("uart_rx: SP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic              rx_meta_q;
  logic              rx_s_q;
  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [D_BITS-1:0] shift_q,    shift_d;
  logic [D_BITS-1:0] data_q,     data_d;
  logic              done_q,     done_d;
  logic              ferr_q,     ferr_d;
  logic              busy_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state and datapath logic for the frame receiver.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end

      // Re-check the line half a bit in; a high line means a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = CNT_ZERO;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = IDX_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Counter is aligned to mid-bit, so every full period lands mid-bit.
      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d              = CNT_ZERO;
          shift_d            = shift_q >> 1'b1;
          shift_d[D_BITS-1]  = rx_s_q;
          if (idx_q == IDX_LAST) begin
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Leaving at mid stop bit lets a back-to-back start edge be caught.
      S_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s_q) begin
            if (stop_idx_q == STOP_LAST) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_idx_d = stop_idx_q + 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A break or misframe: hold off until the line returns high so a
      // line stuck low reports only one error.
      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      idx_q      <= IDX_ZERO;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. dut0 uses the defaults (8 data, 1 stop), dut1
// uses 7 data bits and 2 stop bits. Both run at 109 clocks per bit. Frames are
// driven one bit per 109 cycles starting at #1 after a rising edge; with the
// two-flop synchroniser the receiver enters START 3 edges after the drive, so
// the done/error pulse is seen after edge start + 3 + 54 + 9*109 = start+1038.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DIV     = 109;
  localparam int DONE_AT = 1038;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0;
  logic       rx1;
  logic [7:0] data0;
  logic       done0, ferr0, busy0;
  logic [6:0] data1;
  logic       done1, ferr1, busy1;

  int cyc       = 0;
  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int done_cnt0 = 0;
  int ferr_cnt0 = 0;
  int done_cyc0 = -1;
  int ferr_cyc0 = -1;
  int done_cnt1 = 0;
  int ferr_cnt1 = 0;
  int done_cyc1 = -1;
  int ferr_cyc1 = -1;
  int overlap   = 0;

  uart_rx #(.clk_speed(100_000000), .baudrate(921600), .D_BITS(8), .SP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx0),
    .o_data(data0), .o_rx_done(done0), .o_frame_err(ferr0), .o_busy(busy0)
  );

  uart_rx #(.clk_speed(100_000000), .baudrate(921600), .D_BITS(7), .SP_BITS(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx1),
    .o_data(data1), .o_rx_done(done1), .o_frame_err(ferr1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done0) begin done_cnt0++; done_cyc0 = cyc; end
    if (ferr0) begin ferr_cnt0++; ferr_cyc0 = cyc; end
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    if (ferr1) begin ferr_cnt1++; ferr_cyc1 = cyc; end
    if ((done0 && ferr0) || (done1 && ferr1)) overlap++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a 10-bit frame LSB first (bit 0 = start bit), one bit per DIV cycles.
  task automatic send(input int sel, input logic [9:0] bits, output int s);
    s = cyc;
    for (int i = 0; i < 10; i++) begin
      if (sel == 0) rx0 = bits[i];
      else          rx1 = bits[i];
      step(DIV);
    end
  endtask

  initial begin
    int s;
    int prev;

    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    step(5);
    chk("reset_data",  {24'd0, data0}, 32'h0);
    chk("reset_done",  {31'd0, done0}, 32'h0);
    chk("reset_ferr",  {31'd0, ferr0}, 32'h0);
    chk("reset_busy",  {31'd0, busy0}, 32'h0);
    rst = 1'b0;
    step(20);

    // Single 0xA5 frame.
    send(0, {1'b1, 8'hA5, 1'b0}, s);
    chk("a5_done_cycle", done_cyc0, s + DONE_AT);
    chk("a5_done_count", done_cnt0, 32'd1);
    chk("a5_data",       {24'd0, data0}, 32'hA5);
    chk("a5_no_ferr",    ferr_cnt0, 32'd0);
    step(20);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    send(0, {1'b1, 8'h00, 1'b0}, s);
    chk("b2b_first_cycle", done_cyc0, s + DONE_AT);
    chk("b2b_first_data",  {24'd0, data0}, 32'h00);
    prev = done_cyc0;
    send(0, {1'b1, 8'hFF, 1'b0}, s);
    chk("b2b_second_cycle", done_cyc0, s + DONE_AT);
    chk("b2b_spacing",      done_cyc0 - prev, 32'd1090);
    chk("b2b_second_data",  {24'd0, data0}, 32'hFF);
    chk("b2b_done_count",   done_cnt0, 32'd3);
    step(20);

    // 0x3C with a low stop bit, then the line held low for 300 more cycles.
    send(0, {1'b0, 8'h3C, 1'b0}, s);
    step(300);
    chk("ferr_count",      ferr_cnt0, 32'd1);
    chk("ferr_cycle",      ferr_cyc0, s + DONE_AT);
    chk("ferr_data_kept",  {24'd0, data0}, 32'hFF);
    chk("ferr_busy_low",   {31'd0, busy0}, 32'h1);
    chk("ferr_no_done",    done_cnt0, 32'd3);
    rx0 = 1'b1;
    step(5);
    chk("ferr_busy_release", {31'd0, busy0}, 32'h0);
    chk("ferr_single",       ferr_cnt0, 32'd1);
    step(20);
    send(0, {1'b1, 8'h81, 1'b0}, s);
    chk("after_ferr_data",  {24'd0, data0}, 32'h81);
    chk("after_ferr_cycle", done_cyc0, s + DONE_AT);
    step(20);

    // 20-cycle low glitch on an idle line.
    s = cyc;
    rx0 = 1'b0;
    step(20);
    rx0 = 1'b1;
    step(10);
    chk("glitch_busy_high", {31'd0, busy0}, 32'h1);
    step(40);
    chk("glitch_busy_low",  {31'd0, busy0}, 32'h0);
    chk("glitch_no_done",   done_cnt0, 32'd4);
    chk("glitch_no_ferr",   ferr_cnt0, 32'd1);
    step(20);
    send(0, {1'b1, 8'h3C, 1'b0}, s);
    chk("after_glitch_data",  {24'd0, data0}, 32'h3C);
    chk("after_glitch_cycle", done_cyc0, s + DONE_AT);
    chk("after_glitch_count", done_cnt0, 32'd5);
    step(20);

    // Reset pulse during data bit 4 of 0xF0.
    rx0 = 1'b0;
    step(5 * DIV);
    rx0 = 1'b1;
    step(50);
    chk("pre_reset_busy", {31'd0, busy0}, 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_data", {24'd0, data0}, 32'h0);
    chk("midrst_done", {31'd0, done0}, 32'h0);
    chk("midrst_ferr", {31'd0, ferr0}, 32'h0);
    chk("midrst_busy", {31'd0, busy0}, 32'h0);
    step(300);
    chk("midrst_no_done", done_cnt0, 32'd5);
    chk("midrst_no_ferr", ferr_cnt0, 32'd1);
    send(0, {1'b1, 8'h55, 1'b0}, s);
    chk("after_rst_data",  {24'd0, data0}, 32'h55);
    chk("after_rst_cycle", done_cyc0, s + DONE_AT);
    chk("after_rst_count", done_cnt0, 32'd6);
    step(20);

    // Seven data bits, two stop bits.
    send(1, {1'b1, 1'b1, 7'h2A, 1'b0}, s);
    chk("sp2_done_cycle", done_cyc1, s + DONE_AT);
    chk("sp2_data",       {25'd0, data1}, 32'h2A);
    chk("sp2_done_count", done_cnt1, 32'd1);
    step(20);
    send(1, {1'b0, 1'b1, 7'h2A, 1'b0}, s);
    chk("sp2_ferr_count", ferr_cnt1, 32'd1);
    chk("sp2_ferr_cycle", ferr_cyc1, s + DONE_AT);
    chk("sp2_no_done",    done_cnt1, 32'd1);
    rx1 = 1'b1;
    step(10);
    chk("sp2_busy_release", {31'd0, busy1}, 32'h0);

    chk("done_ferr_overlap", overlap, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
